// File: rtl/count_led_sequencer_if.sv
// Connection between the upstream counter, the LED sequencer and the board LEDs.
// The counter side drives count/mode/run; the sequencer drives the pattern and tick.
interface count_led_sequencer_if #(
    parameter int NLEDS = 8
);
    logic [23:0]      data;
    logic [1:0]       mode;
    logic             run;
    logic [NLEDS-1:0] leds;
    logic             tick;

    modport master (
        output data, mode, run,
        input  leds, tick
    );

    modport slave (
        input  data, mode, run,
        output leds, tick
    );
endinterface

// File: rtl/count_led_sequencer.sv
// Taps one bit of the free-running counter as a time base and steps an LED
// pattern state machine on every rising edge of that bit while run is high.
module count_led_sequencer #(
    parameter int TAP   = 21,
    parameter int NLEDS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    count_led_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        BINARY,
        RING,
        BOUNCE_L,
        BOUNCE_R,
        FILL
    } state_t;

    localparam logic [NLEDS-1:0] LSB_ONLY = NLEDS'(1);
    localparam logic [NLEDS-1:0] MSB_ONLY = LSB_ONLY << (NLEDS - 1);
    localparam logic [NLEDS-1:0] ALL_ONES = '1;

    state_t           state;
    state_t           state_next;
    state_t           entry;
    logic [NLEDS-1:0] leds;
    logic [NLEDS-1:0] leds_next;
    logic [NLEDS-1:0] shl;
    logic [NLEDS-1:0] shr;
    logic [NLEDS-1:0] rotl;
    logic             tap_q;
    logic             tick;
    logic             step;
    logic             match;
    logic             data_unused;

    // Only the tapped bit matters; the rest of the count is folded away here.
    assign data_unused = ^(bus.data & ~(24'(1) << TAP));

    assign step = tick & bus.run;
    assign shl  = {leds[NLEDS-2:0], 1'b0};
    assign shr  = {1'b0, leds[NLEDS-1:1]};
    assign rotl = {leds[NLEDS-2:0], leds[NLEDS-1]};

    always_comb begin
        entry = FILL;
        case (bus.mode)
            2'd0:    entry = BINARY;
            2'd1:    entry = RING;
            2'd2:    entry = BOUNCE_L;
            default: entry = FILL;
        endcase
    end

    // Both bounce directions belong to mode 2, so either one counts as a match.
    assign match = (state == entry) || ((state == BOUNCE_R) && (entry == BOUNCE_L));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RING;
            leds  <= LSB_ONLY;
            tap_q <= 1'b1;
            tick  <= 1'b0;
        end else begin
            state <= state_next;
            leds  <= leds_next;
            tap_q <= bus.data[TAP];
            tick  <= bus.data[TAP] & ~tap_q;
        end
    end

    always_comb begin
        state_next = state;
        if (step) begin
            if (!match) begin
                state_next = entry;
            end else if ((state == BOUNCE_L) && (shl == MSB_ONLY)) begin
                state_next = BOUNCE_R;
            end else if ((state == BOUNCE_R) && (shr == LSB_ONLY)) begin
                state_next = BOUNCE_L;
            end
        end
    end

    always_comb begin
        leds_next = leds;
        if (step) begin
            if (!match) begin
                case (entry)
                    RING, BOUNCE_L: leds_next = LSB_ONLY;
                    default:        leds_next = '0;
                endcase
            end else begin
                case (state)
                    BINARY:   leds_next = leds + LSB_ONLY;
                    RING:     leds_next = rotl;
                    BOUNCE_L: leds_next = shl;
                    BOUNCE_R: leds_next = shr;
                    FILL:     leds_next = (leds == ALL_ONES) ? '0 : {leds[NLEDS-2:0], 1'b1};
                    default:  leds_next = LSB_ONLY;
                endcase
            end
        end
    end

    assign bus.leds = leds;
    assign bus.tick = tick;
endmodule
